// File: rtl/cr16_mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cr16_mmio_pkg
// Description : Register offsets and TMR_CTRL bit indices of the CR16 MMIO
//               window, shared with assembler test programs.
// Revision    : 1.0 - initial release
// ============================================================================
package cr16_mmio_pkg;

    typedef logic [2:0] reg_offset_t;

    localparam reg_offset_t DISPLAY    = 3'd0;
    localparam reg_offset_t LEDS       = 3'd1;
    localparam reg_offset_t SWITCHES   = 3'd2;
    localparam reg_offset_t BTN_EVENTS = 3'd3;
    localparam reg_offset_t TMR_RELOAD = 3'd4;
    localparam reg_offset_t TMR_COUNT  = 3'd5;
    localparam reg_offset_t TMR_CTRL   = 3'd6;
    localparam reg_offset_t RESERVED   = 3'd7;

    localparam int ENABLE  = 0;
    localparam int EXPIRED = 1;

    function automatic int prescale_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cr16_mmio_responder_sync.sv
`default_nettype none
// ============================================================================
// Module      : sync_rise_detect
// Description : 2-flop synchronizer plus previous-value flop; gives the
//               synchronized level and a one-cycle rising-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_rise_detect #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_level,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/cr16_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module      : cr16_mmio_responder
// Description : 8-word MMIO window on the CR16 external memory port: display,
//               LEDs, switches, button events and a prescaled down-timer.
// Revision    : 1.0 - initial release
// ============================================================================
module cr16_mmio_responder
    import cr16_mmio_pkg::*;
#(
    parameter logic [15:0] P_BASE_ADDRESS   = 16'hFFF8,
    parameter int          P_TIMER_PRESCALE = 50000
) (
    input  logic        I_CLK,
    input  logic        I_RESET,
    input  logic [15:0] I_MEM_ADDRESS,
    input  logic [15:0] I_MEM_DATA,
    input  logic        I_MEM_WRITE_ENABLE,
    output logic [15:0] O_MEM_DATA,
    input  logic [9:0]  I_SWITCHES,
    input  logic [3:0]  I_BUTTONS,
    output logic [15:0] O_DISPLAY_VALUE,
    output logic [4:0]  O_LEDS,
    output logic        O_TIMER_EXPIRED
);

    localparam int                 c_PSC_W    = prescale_width(P_TIMER_PRESCALE);
    localparam logic [c_PSC_W-1:0] c_PSC_LAST = c_PSC_W'(P_TIMER_PRESCALE - 1);

    logic [15:0]        r_display;
    logic [4:0]         r_leds;
    logic [3:0]         r_btn_events;
    logic [15:0]        r_reload;
    logic [15:0]        r_count;
    logic               r_enable;
    logic               r_expired;
    logic [c_PSC_W-1:0] r_prescale;
    logic [15:0]        r_rdata;

    logic [9:0]  w_sw_level;
    logic [9:0]  w_sw_rise_unused;
    logic [3:0]  w_btn_level_unused;
    logic [3:0]  w_btn_rise;
    logic        w_hit;
    reg_offset_t w_off;
    logic        w_wr;
    logic        w_reload_wr;
    logic        w_ctrl_wr;
    logic        w_tick;
    logic        w_expire;
    logic [3:0]  w_btn_clear;
    logic        w_exp_clear;
    logic [15:0] w_rd_value;

    sync_rise_detect #(.WIDTH(10)) u_sync_switches (
        .clk     (I_CLK),
        .rst     (I_RESET),
        .i_async (I_SWITCHES),
        .o_level (w_sw_level),
        .o_rise  (w_sw_rise_unused)
    );

    sync_rise_detect #(.WIDTH(4)) u_sync_buttons (
        .clk     (I_CLK),
        .rst     (I_RESET),
        .i_async (I_BUTTONS),
        .o_level (w_btn_level_unused),
        .o_rise  (w_btn_rise)
    );

    assign w_hit       = (I_MEM_ADDRESS[15:3] == P_BASE_ADDRESS[15:3]);
    assign w_off       = I_MEM_ADDRESS[2:0];
    assign w_wr        = w_hit && I_MEM_WRITE_ENABLE;
    assign w_reload_wr = w_wr && (w_off == TMR_RELOAD);
    assign w_ctrl_wr   = w_wr && (w_off == TMR_CTRL);
    assign w_tick      = r_enable && (r_prescale == c_PSC_LAST);
    // A reload write swallows a coincident tick, so it cannot expire either.
    assign w_expire    = w_tick && !w_reload_wr && (r_count == 16'd0);
    assign w_btn_clear = (w_wr && (w_off == BTN_EVENTS)) ? I_MEM_DATA[3:0] : 4'b0000;
    assign w_exp_clear = w_ctrl_wr && I_MEM_DATA[EXPIRED];

    always_comb begin
        w_rd_value = 16'h0000;
        if (w_hit) begin
            case (w_off)
                DISPLAY:    w_rd_value = r_display;
                LEDS:       w_rd_value = {11'b0, r_leds};
                SWITCHES:   w_rd_value = {6'b0, w_sw_level};
                BTN_EVENTS: w_rd_value = {12'b0, r_btn_events};
                TMR_RELOAD: w_rd_value = r_reload;
                TMR_COUNT:  w_rd_value = r_count;
                TMR_CTRL:   w_rd_value = {14'b0, r_expired, r_enable};
                default:    w_rd_value = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_display    <= '0;
            r_leds       <= '0;
            r_btn_events <= '0;
            r_reload     <= '0;
            r_count      <= '0;
            r_enable     <= 1'b0;
            r_expired    <= 1'b0;
            r_prescale   <= '0;
            r_rdata      <= '0;
        end else begin
            r_rdata <= w_rd_value;

            if (w_wr && (w_off == DISPLAY)) r_display <= I_MEM_DATA;
            if (w_wr && (w_off == LEDS))    r_leds    <= I_MEM_DATA[4:0];
            if (w_ctrl_wr)                  r_enable  <= I_MEM_DATA[ENABLE];

            // Set terms are OR-ed in after the clear so a coincident event wins.
            r_btn_events <= (r_btn_events & ~w_btn_clear) | w_btn_rise;
            r_expired    <= (r_expired & ~w_exp_clear) | w_expire;

            if (w_reload_wr) begin
                r_reload   <= I_MEM_DATA;
                r_count    <= I_MEM_DATA;
                r_prescale <= '0;
            end else if (w_tick) begin
                r_prescale <= '0;
                if (r_count == 16'd0) r_count <= r_reload;
                else                  r_count <= r_count - 16'd1;
            end else if (r_enable) begin
                r_prescale <= r_prescale + 1'b1;
            end
        end
    end

    assign O_MEM_DATA      = r_rdata;
    assign O_DISPLAY_VALUE = r_display;
    assign O_LEDS          = r_leds;
    assign O_TIMER_EXPIRED = r_expired;

endmodule
`default_nettype wire
